pc_fetch: RTL
=============

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_VEC, default 10'h000, PC value loaded on reset.
REQ-002 Parameter INTR_VEC, default 10'h3FF, PC target when PC_MUX_SEL = 2.
REQ-003 CLK  input  1  single system clock; all state updates on rising edge.
REQ-004 RST_N  input  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
REQ-005 PC_LD  input  1  load PC from the source chosen by PC_MUX_SEL.
REQ-006 PC_INC  input  1  increment PC by 1.
REQ-007 PC_MUX_SEL  input  2  load source: 0 FROM_IMMED, 1 FROM_STACK, 2 INTR_VEC, 3 reserved.
REQ-008 FROM_IMMED  input  10  branch/call target from instruction field.
REQ-009 FROM_STACK  input  10  return address from scratch RAM.
REQ-010 STALL  input  1  freeze PC and fetch status this cycle.
REQ-011 PC_COUNT  output  10  current PC; drives program ROM address directly.
REQ-012 PC_PLUS1  output  10  PC_COUNT + 1 modulo 1024, combinational; return address for CALL.
REQ-013 IR_VALID  output  1  high when the ROM instruction output matches the PC of the previous cycle with no intervening redirect.
REQ-014 WRAP_ERR  output  1  sticky flag; PC incremented past 10'h3FF.

Function
REQ-015 PC_COUNT shall be a 10-bit register updated only on CLK rising edge.
REQ-016 Priority, highest first: STALL, PC_LD, PC_INC, hold.
REQ-017 STALL = 1: PC_COUNT, IR_VALID, and WRAP_ERR hold; PC_LD and PC_INC ignored.
REQ-018 PC_LD = 1, STALL = 0: PC_COUNT <= the source selected by PC_MUX_SEL; PC_INC ignored that cycle.
REQ-019 PC_MUX_SEL = 3 with PC_LD: PC_COUNT holds; treated as a redirect for IR_VALID purposes.
REQ-020 PC_INC = 1, PC_LD = 0, STALL = 0: PC_COUNT <= PC_COUNT + 1 modulo 1024.
REQ-021 Increment from 10'h3FF: PC_COUNT becomes 10'h000 and WRAP_ERR sets to 1 the same edge; WRAP_ERR clears only on reset.
REQ-022 Load of 10'h3FF followed by a load elsewhere shall not set WRAP_ERR; only an increment from 10'h3FF sets it.
REQ-023 Program ROM has 1-cycle synchronous read latency. IR_VALID follows a 2-state FSM:
  - BUBBLE: IR_VALID = 0.
  - RUN: IR_VALID = 1.
REQ-024 FSM transitions, evaluated when STALL = 0:
  - BUBBLE -> RUN.
  - RUN -> BUBBLE on PC_LD.
  - RUN -> RUN otherwise.
  - STALL = 1 holds the state.
REQ-025 IR_VALID shall be a registered output decoded from FSM state only.
REQ-026 PC_PLUS1 shall be purely combinational from PC_COUNT, with no dependency on control inputs.

Reset
REQ-027 RST_N low shall immediately, without waiting for CLK, force:
  - PC_COUNT = RESET_VEC
  - FSM = BUBBLE (IR_VALID = 0)
  - WRAP_ERR = 0
REQ-028 While RST_N is low, all inputs are ignored.
REQ-029 On the first rising edge after RST_N deasserts, normal priority rules apply and the FSM leaves BUBBLE (unless STALL = 1).
REQ-030 Reset asserted mid-load or mid-stall shall abort the operation; no partial PC value is retained.

Verification
REQ-031 Reset release, then PC_INC = 1 for 4 cycles -> PC_COUNT: 000, 001, 002, 003, 004; IR_VALID: 0, 1, 1, 1, 1; PC_PLUS1 = PC_COUNT + 1 each cycle.
REQ-032 PC_COUNT = 10'h025, PC_LD = 1, PC_MUX_SEL = 0, FROM_IMMED = 10'h100, PC_INC = 1 -> PC_COUNT = 10'h100 next edge, IR_VALID = 0 for one cycle then 1.
REQ-033 PC_COUNT = 10'h3FE, PC_INC held high -> 3FF, then 000 with WRAP_ERR = 1; WRAP_ERR stays 1 through a later load; clears only on RST_N low.
REQ-034 STALL = 1 for 3 cycles with PC_LD = 1, PC_MUX_SEL = 2 -> PC_COUNT and IR_VALID unchanged; STALL drops -> PC_COUNT = 10'h3FF, IR_VALID = 0 next cycle.
REQ-035 PC_MUX_SEL = 1, FROM_STACK = 10'h0A7, PC_LD = 1 -> PC_COUNT = 10'h0A7; PC_MUX_SEL = 3 with PC_LD -> PC_COUNT holds 10'h0A7, IR_VALID drops for one cycle.
REQ-036 RST_N pulsed low between clock edges while PC_COUNT = 10'h155 -> PC_COUNT = RESET_VEC, IR_VALID = 0, WRAP_ERR = 0 before the next CLK edge.

Source files
------------

// File: rtl/pc_fetch.sv
// -----------------------------------------------------------------------------
// pc_fetch
//   Program counter and fetch-status tracker for a processor with a
//   single-cycle synchronous program ROM. PC_COUNT addresses the ROM directly.
//   IR_VALID tells the decoder whether the word now on the ROM output belongs
//   to the sequential fetch stream. It drops for one cycle after any redirect.
//
// Parameters
//   RESET_VEC  : PC value forced while RST_N is low
//   INTR_VEC   : load target when PC_MUX_SEL = 2
//
// Ports
//   CLK        in   system clock; all state changes on the rising edge
//   RST_N      in   asynchronous active-low reset
//   PC_LD      in   load PC from the source chosen by PC_MUX_SEL
//   PC_INC     in   increment PC by one
//   PC_MUX_SEL in   0 immediate, 1 stack, 2 interrupt vector, 3 reserved (hold)
//   FROM_IMMED in   branch/call target from the instruction field
//   FROM_STACK in   return address from scratch RAM
//   STALL      in   freeze PC, fetch status and wrap flag this cycle
//   PC_COUNT   out  current PC (registered)
//   PC_PLUS1   out  PC_COUNT + 1 modulo 1024 (combinational, CALL return addr)
//   IR_VALID   out  ROM output matches the previous PC with no redirect
//   WRAP_ERR   out  sticky: PC was incremented past 10'h3FF
// -----------------------------------------------------------------------------
module pc_fetch #(
  parameter logic [9:0] RESET_VEC = 10'h000,
  parameter logic [9:0] INTR_VEC  = 10'h3FF
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       PC_LD,
  input  logic       PC_INC,
  input  logic [1:0] PC_MUX_SEL,
  input  logic [9:0] FROM_IMMED,
  input  logic [9:0] FROM_STACK,
  input  logic       STALL,
  output logic [9:0] PC_COUNT,
  output logic [9:0] PC_PLUS1,
  output logic       IR_VALID,
  output logic       WRAP_ERR
);

  typedef enum logic [0:0] {
    ST_BUBBLE = 1'b0,
    ST_RUN    = 1'b1
  } fetch_state_t;

  logic [9:0]   pc_r;
  logic [9:0]   pc_next_s;
  logic [9:0]   pc_plus1_s;
  logic         wrap_r;
  logic         wrap_next_s;
  fetch_state_t state_r;
  fetch_state_t state_next_s;

  // Incrementer shared by the PC_INC path and the PC_PLUS1 output.
  assign pc_plus1_s = pc_r + 10'd1;

  // PC and wrap-flag next-value selection, priority STALL > PC_LD > PC_INC.
  always_comb begin
    pc_next_s   = pc_r;
    wrap_next_s = wrap_r;
    if (STALL) begin
      pc_next_s   = pc_r;
      wrap_next_s = wrap_r;
    end else if (PC_LD) begin
      // A reserved select still counts as a redirect for the FSM, but the
      // PC keeps its value.
      case (PC_MUX_SEL)
        2'd0:    pc_next_s = FROM_IMMED;
        2'd1:    pc_next_s = FROM_STACK;
        2'd2:    pc_next_s = INTR_VEC;
        default: pc_next_s = pc_r;
      endcase
      wrap_next_s = wrap_r;
    end else if (PC_INC) begin
      pc_next_s = pc_plus1_s;
      // Only an increment out of the top address is a wrap; loads never are.
      if (pc_r == 10'h3FF) begin
        wrap_next_s = 1'b1;
      end else begin
        wrap_next_s = wrap_r;
      end
    end else begin
      pc_next_s   = pc_r;
      wrap_next_s = wrap_r;
    end
  end

  // Fetch-status FSM next state: a load from RUN inserts one bubble because
  // the ROM output then belongs to the abandoned sequential address.
  always_comb begin
    state_next_s = state_r;
    if (STALL) begin
      state_next_s = state_r;
    end else begin
      case (state_r)
        ST_BUBBLE: state_next_s = ST_RUN;
        ST_RUN: begin
          if (PC_LD) begin
            state_next_s = ST_BUBBLE;
          end else begin
            state_next_s = ST_RUN;
          end
        end
        default:   state_next_s = ST_BUBBLE;
      endcase
    end
  end

  // State registers with asynchronous reset to the reset vector / bubble.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_r    <= RESET_VEC;
      wrap_r  <= 1'b0;
      state_r <= ST_BUBBLE;
    end else begin
      pc_r    <= pc_next_s;
      wrap_r  <= wrap_next_s;
      state_r <= state_next_s;
    end
  end

  assign PC_COUNT = pc_r;
  assign PC_PLUS1 = pc_plus1_s;
  assign WRAP_ERR = wrap_r;
  // Decoded straight from the state flop, so the output is glitch-free.
  assign IR_VALID = (state_r == ST_RUN);

endmodule
